// File: rtl/cargador_trabajo.sv
// Job loader / result collector in front of the sistema_area core: assembles a 13-byte job,
// runs the core until terminado, then offers nonce/hash on a valid/ready port.
// Optional RUN-cycle abort is built when CARGADOR_TIMEOUT_EN is defined.
module cargador_trabajo #(
    parameter int unsigned MAX_CICLOS = 1048576
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [95:0] payload,
    output logic [7:0]  target,
    output logic        active,
    input  logic        terminado,
    input  logic [31:0] nonceIn,
    input  logic [23:0] hashIn,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_nonce,
    output logic [23:0] res_hash,
    output logic        res_timeout
);

    typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DONE} state_t;

    // The abort counter is 21 bits wide, so the budget must fit in it.
    if (MAX_CICLOS < 1 || MAX_CICLOS > (1 << 21)) begin : g_bad_max_ciclos
        $error("cargador_trabajo: MAX_CICLOS out of range");
    end

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [95:0] payload_q, payload_d;
    logic [7:0]  target_q, target_d;
    logic        active_q, active_d;
    logic        res_valid_q, res_valid_d;
    logic [31:0] res_nonce_q, res_nonce_d;
    logic [23:0] res_hash_q, res_hash_d;

`ifdef CARGADOR_TIMEOUT_EN
    localparam logic [20:0] CNT_LAST = 21'(MAX_CICLOS - 1);
    logic [20:0] cnt_q, cnt_d;
    logic        res_timeout_q, res_timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        payload_d   = payload_q;
        target_d    = target_q;
        active_d    = active_q;
        res_valid_d = res_valid_q;
        res_nonce_d = res_nonce_q;
        res_hash_d  = res_hash_q;
`ifdef CARGADOR_TIMEOUT_EN
        cnt_d         = cnt_q;
        res_timeout_d = res_timeout_q;
`endif
        unique case (state_q)
            ST_LOAD: begin
                if (byte_valid) begin
                    if (idx_q == 4'd12) begin
                        target_d = byte_in;
                        idx_d    = 4'd0;
                        active_d = 1'b1;
                        state_d  = ST_RUN;
`ifdef CARGADOR_TIMEOUT_EN
                        cnt_d = 21'd0;
`endif
                    end else begin
                        // First byte lands in the payload MSB.
                        payload_d[95 - 8*int'(idx_q) -: 8] = byte_in;
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_RUN: begin
                if (terminado) begin
                    res_nonce_d = nonceIn;
                    res_hash_d  = hashIn;
                    active_d    = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
`ifdef CARGADOR_TIMEOUT_EN
                    res_timeout_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    res_nonce_d   = nonceIn;
                    res_hash_d    = hashIn;
                    active_d      = 1'b0;
                    res_valid_d   = 1'b1;
                    res_timeout_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 21'd1;
`endif
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_LOAD;
            idx_q       <= 4'd0;
            payload_q   <= '0;
            target_q    <= '0;
            active_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_nonce_q <= '0;
            res_hash_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            payload_q   <= payload_d;
            target_q    <= target_d;
            active_q    <= active_d;
            res_valid_q <= res_valid_d;
            res_nonce_q <= res_nonce_d;
            res_hash_q  <= res_hash_d;
        end
    end

`ifdef CARGADOR_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            res_timeout_q <= res_timeout_d;
        end
    end
    assign res_timeout = res_timeout_q;
`else
    assign res_timeout = 1'b0;
`endif

    assign byte_ready = (state_q == ST_LOAD);
    assign payload    = payload_q;
    assign target     = target_q;
    assign active     = active_q;
    assign res_valid  = res_valid_q;
    assign res_nonce  = res_nonce_q;
    assign res_hash   = res_hash_q;

endmodule

// File: tb/tb_cargador_trabajo.sv
// Bench for cargador_trabajo: directed job flows plus randomized jobs, gaps, run lengths
// and backpressure, checked against a job-level expectation model.
module tb_cargador_trabajo;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [95:0] payload;
    logic [7:0]  target;
    logic        active;
    logic        terminado;
    logic [31:0] nonceIn;
    logic [23:0] hashIn;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_nonce;
    logic [23:0] res_hash;
    logic        res_timeout;

    cargador_trabajo #(.MAX_CICLOS(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .payload(payload), .target(target), .active(active),
        .terminado(terminado), .nonceIn(nonceIn), .hashIn(hashIn),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_nonce(res_nonce), .res_hash(res_hash), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Expected externally visible job state.
    logic [95:0] exp_payload;
    logic [7:0]  exp_target;
    logic [31:0] exp_nonce;
    logic [23:0] exp_hash;
    logic        exp_timeout;

    logic [7:0] job [13];
    logic [7:0] basic_job [13] = '{8'h39, 8'h7d, 8'h9f, 8'h2f, 8'h40, 8'hca, 8'h9e,
                                    8'h6c, 8'h6b, 8'h1f, 8'h33, 8'h24, 8'h0a};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_values();
        chk("rst_payload", payload, 0);
        chk("rst_target", target, 0);
        chk("rst_active", active, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_nonce", res_nonce, 0);
        chk("rst_res_hash", res_hash, 0);
        chk("rst_res_timeout", res_timeout, 0);
        chk("rst_byte_ready", byte_ready, 1);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        byte_valid = 1'b0;
        terminado = 1'b0;
        res_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_payload = '0;
        exp_target = '0;
        exp_nonce = '0;
        exp_hash = '0;
        exp_timeout = 1'b0;
        check_reset_values();
    endtask

    // Feed the first n bytes of job with gmin..gmax idle cycles before each byte.
    task automatic load_bytes(input int n, input int gmin, input int gmax);
        for (int k = 0; k < n; k++) begin
            int idle = $urandom_range(gmax, gmin);
            for (int g = 0; g < idle; g++) begin
                byte_valid = 1'b0;
                byte_in = 8'($urandom);
                terminado = 1'($urandom);
                tick();
            end
            terminado = 1'b0;
            byte_valid = 1'b1;
            byte_in = job[k];
            chk("load_byte_ready", byte_ready, 1);
            chk("load_active_low", active, 0);
            tick();
            if (k < 12) exp_payload[95 - 8*k -: 8] = job[k];
            else exp_target = job[k];
            chk("load_payload", payload, exp_payload);
            chk("load_target", target, exp_target);
        end
        byte_valid = 1'b0;
        terminado = 1'b0;
    endtask

    task automatic load_job(input int gmin, input int gmax);
        load_bytes(13, gmin, gmax);
        chk("job_active", active, 1);
        chk("job_byte_ready", byte_ready, 0);
        chk("job_res_valid", res_valid, 0);
    endtask

    // Stay in RUN for 'cycles' edges (junk bytes offered), then complete.
    task automatic run_job(input int cycles, input logic [31:0] n, input logic [23:0] h);
        for (int i = 0; i < cycles; i++) begin
            byte_valid = 1'b1;
            byte_in = 8'($urandom);
            nonceIn = $urandom;
            hashIn = 24'($urandom);
            tick();
            chk("run_active", active, 1);
            chk("run_byte_ready", byte_ready, 0);
            chk("run_payload_frozen", payload, exp_payload);
            chk("run_target_frozen", target, exp_target);
        end
        byte_valid = 1'b0;
        terminado = 1'b1;
        nonceIn = n;
        hashIn = h;
        tick();
        terminado = 1'b0;
        nonceIn = $urandom;
        hashIn = 24'($urandom);
        exp_nonce = n;
        exp_hash = h;
        exp_timeout = 1'b0;
        chk("done_active", active, 0);
        chk("done_res_valid", res_valid, 1);
        chk("done_res_nonce", res_nonce, exp_nonce);
        chk("done_res_hash", res_hash, exp_hash);
        chk("done_res_timeout", res_timeout, exp_timeout);
    endtask

    // Hold res_ready low for bp cycles with bytes offered, then handshake.
    task automatic drain(input int bp);
        res_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            byte_valid = 1'b1;
            byte_in = 8'($urandom);
            terminado = 1'($urandom);
            tick();
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_nonce", res_nonce, exp_nonce);
            chk("bp_res_hash", res_hash, exp_hash);
            chk("bp_res_timeout", res_timeout, exp_timeout);
            chk("bp_byte_ready", byte_ready, 0);
            chk("bp_payload", payload, exp_payload);
            chk("bp_active", active, 0);
        end
        byte_valid = 1'b0;
        terminado = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("ack_res_valid", res_valid, 0);
        chk("ack_byte_ready", byte_ready, 1);
    endtask

    initial begin
        reset_n = 1'b1;
        byte_in = '0;
        byte_valid = 1'b0;
        terminado = 1'b0;
        nonceIn = '0;
        hashIn = '0;
        res_ready = 1'b0;
        tick();
        pulse_reset();

        // Basic load, completion, backpressure.
        job = basic_job;
        load_job(0, 0);
        chk("basic_payload", payload, 96'h397d9f2f40ca9e6c6b1f3324);
        chk("basic_target", target, 8'h0a);
        run_job(20, 32'h00001234, 24'h05abcd);
        drain(5);

        // Gapped input, same job, after a different job has overwritten the registers.
        for (int k = 0; k < 13; k++) job[k] = 8'($urandom);
        load_job(0, 0);
        run_job(3, 32'hdeadbeef, 24'h123456);
        drain(0);
        job = basic_job;
        load_job(1, 1);
        chk("gap_payload", payload, 96'h397d9f2f40ca9e6c6b1f3324);
        chk("gap_target", target, 8'h0a);
        run_job(0, 32'h0000abcd, 24'h00ffee);
        drain(1);

        // Reset after 6 bytes, then a full load must start from index 0.
        for (int k = 0; k < 13; k++) job[k] = 8'($urandom);
        load_bytes(6, 0, 2);
        pulse_reset();
        job = basic_job;
        load_job(0, 1);
        chk("rst_reload_payload", payload, 96'h397d9f2f40ca9e6c6b1f3324);

        // Reset while in RUN.
        for (int i = 0; i < 4; i++) tick();
        chk("rst_run_active_pre", active, 1);
        pulse_reset();
        job = basic_job;
        load_job(0, 0);
        run_job(2, 32'h11112222, 24'h333444);
        // Reset while in DONE.
        pulse_reset();

`ifdef CARGADOR_TIMEOUT_EN
        // Abort after 16 RUN cycles with terminado held low.
        for (int k = 0; k < 13; k++) job[k] = 8'($urandom);
        load_job(0, 1);
        for (int i = 0; i < 16; i++) begin
            chk("to_active_hold", active, 1);
            nonceIn = 32'hcafe0000 + 32'(i);
            hashIn = 24'h0a0000 + 24'(i);
            tick();
        end
        exp_nonce = 32'hcafe000f;
        exp_hash = 24'h0a000f;
        exp_timeout = 1'b1;
        chk("to_active", active, 0);
        chk("to_res_valid", res_valid, 1);
        chk("to_res_timeout", res_timeout, 1);
        chk("to_res_nonce", res_nonce, exp_nonce);
        chk("to_res_hash", res_hash, exp_hash);
        drain(2);

        // terminado on the 16th RUN cycle wins over the abort.
        load_job(0, 0);
        for (int i = 0; i < 15; i++) begin
            chk("to2_active_hold", active, 1);
            tick();
        end
        terminado = 1'b1;
        nonceIn = 32'h0badf00d;
        hashIn = 24'h00c0de;
        tick();
        terminado = 1'b0;
        exp_nonce = 32'h0badf00d;
        exp_hash = 24'h00c0de;
        exp_timeout = 1'b0;
        chk("to2_res_valid", res_valid, 1);
        chk("to2_res_timeout", res_timeout, 0);
        chk("to2_res_nonce", res_nonce, exp_nonce);
        drain(1);
`endif

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 13; k++) job[k] = 8'($urandom);
            load_job(0, 3);
`ifdef CARGADOR_TIMEOUT_EN
            run_job($urandom_range(14, 0), $urandom, 24'($urandom));
`else
            run_job($urandom_range(40, 0), $urandom, 24'($urandom));
`endif
            drain($urandom_range(6, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
